// File: rtl/conv_window_sched.sv
// conv_window_sched
// Raster-order sequencer for a 3x3 sliding-window convolution datapath.
// Walks an IMG_W x IMG_H image with a stride of 1..3. It drives the
// line-buffer column shifts and the window-register loads, and it raises
// window_valid once for every output pixel.
//
// Ports:
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   start          begins a frame; sampled only while idle
//   stride         window step (0 is treated as 1), latched at start
//   mac_ready      MAC array accepts the presented window this cycle
//   shift_buffer   line buffers present the next column (equal to window_en)
//   window_en      window registers shift in the current column
//   window_valid   window registers hold a complete window
//   row_advance    1-cycle pulse: line buffers step down by row_step rows
//   row_step       latched effective stride
//   win_col/win_row  top-left corner of the presented window
//   busy           high from accepted start until done
//   done           1-cycle end-of-frame pulse
//   stall_cnt/win_cnt  performance counters (only with CONV_SCHED_PERF_EN)
//   state_dbg      current FSM state encoding
//
// Optional feature macro: CONV_SCHED_PERF_EN
//
// Handshake: a window transfers on every cycle where window_valid and
// mac_ready are both high. While window_valid is high and mac_ready is low,
// all outputs hold and no column is shifted.
module conv_window_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CW    = 8,
  parameter int RW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    stride,
  input  logic          mac_ready,
  output logic          shift_buffer,
  output logic          window_en,
  output logic          window_valid,
  output logic          row_advance,
  output logic [1:0]    row_step,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          busy,
  output logic          done,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]   stall_cnt,
  output logic [15:0]   win_cnt,
`endif
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRIME    = 3'd1,
    S_EMIT     = 3'd2,
    S_STEP     = 3'd3,
    S_NEXT_ROW = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  localparam logic [CW:0]   W_LIM = (CW+1)'(IMG_W);
  localparam logic [RW+1:0] H_LIM = (RW+2)'(IMG_H);

  state_t        state_q, state_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [1:0]    stride_q, stride_d;
  logic [1:0]    phase_q, phase_d;

  logic          shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          row_adv_q, row_adv_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic [15:0]   win_cnt_q, win_cnt_d;
`endif

  // Look-ahead sums, widened by one/two bits so the bound tests cannot wrap.
  logic [CW:0]   col_sum;
  logic [RW+1:0] row_sum;
  logic          handshake;

  assign col_sum   = {1'b0, col_cnt_q} + (CW+1)'(stride_q);
  assign row_sum   = {2'b00, row_cnt_q} + (RW+2)'(stride_q) + (RW+2)'(3);
  assign handshake = (state_q == S_EMIT) && mac_ready;

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    stride_d  = stride_q;
    phase_d   = phase_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stride_d  = (stride == 2'd0) ? 2'd1 : stride;
          col_cnt_d = '0;
          row_cnt_d = '0;
          phase_d   = 2'd0;
          state_d   = S_PRIME;
        end
      end
      // Fill the three window columns before the first window of a row.
      S_PRIME: begin
        col_cnt_d = col_cnt_q + CW'(1);
        if (phase_q == 2'd2) begin
          phase_d = 2'd0;
          state_d = S_EMIT;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      S_EMIT: begin
        if (mac_ready) begin
          phase_d = 2'd0;
          if (col_sum <= W_LIM) begin
            state_d = S_STEP;
          end else if (row_sum <= H_LIM) begin
            state_d = S_NEXT_ROW;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_STEP: begin
        col_cnt_d = col_cnt_q + CW'(1);
        if (phase_q == 2'(stride_q - 2'd1)) begin
          phase_d = 2'd0;
          state_d = S_EMIT;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      S_NEXT_ROW: begin
        row_cnt_d = row_cnt_q + RW'(stride_q);
        col_cnt_d = '0;
        phase_d   = 2'd0;
        state_d   = S_PRIME;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    shift_d   = (state_d == S_PRIME) || (state_d == S_STEP);
    valid_d   = (state_d == S_EMIT);
    row_adv_d = (state_d == S_NEXT_ROW);
    done_d    = (state_d == S_FIN);
    busy_d    = (state_d != S_IDLE) && (state_d != S_FIN);
    win_col_d = valid_d ? (col_cnt_d - CW'(3)) : win_col_q;
    win_row_d = valid_d ? row_cnt_d : win_row_q;

`ifdef CONV_SCHED_PERF_EN
    stall_cnt_d = stall_cnt_q;
    win_cnt_d   = win_cnt_q;
    if ((state_q == S_IDLE) && start) begin
      stall_cnt_d = '0;
      win_cnt_d   = '0;
    end else if (state_q == S_EMIT) begin
      if (handshake) begin
        win_cnt_d = win_cnt_q + 16'd1;
      end else begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      stride_q  <= 2'd0;
      phase_q   <= 2'd0;
      shift_q   <= 1'b0;
      valid_q   <= 1'b0;
      row_adv_q <= 1'b0;
      win_col_q <= '0;
      win_row_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CONV_SCHED_PERF_EN
      stall_cnt_q <= '0;
      win_cnt_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      stride_q  <= stride_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      row_adv_q <= row_adv_d;
      win_col_q <= win_col_d;
      win_row_q <= win_row_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CONV_SCHED_PERF_EN
      stall_cnt_q <= stall_cnt_d;
      win_cnt_q   <= win_cnt_d;
`endif
    end
  end

  assign shift_buffer = shift_q;
  assign window_en    = shift_q;
  assign window_valid = valid_q;
  assign row_advance  = row_adv_q;
  assign row_step     = stride_q;
  assign win_col      = win_col_q;
  assign win_row      = win_row_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign state_dbg    = state_q;
`ifdef CONV_SCHED_PERF_EN
  assign stall_cnt    = stall_cnt_q;
  assign win_cnt      = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched (8x8 image). Expected window coordinates are
// pushed into exp_q before each frame; a negedge monitor pops and compares
// on every window_valid && mac_ready handshake.
module tb_conv_window_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] stride;
  logic       mac_ready;
  logic       shift_buffer, window_en, window_valid, row_advance, busy, done;
  logic [1:0] row_step;
  logic [7:0] win_col;
  logic [7:0] win_row;
  logic [2:0] state_dbg;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] win_cnt;
`endif

  conv_window_sched #(.IMG_W(8), .IMG_H(8), .CW(8), .RW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stride(stride), .mac_ready(mac_ready),
    .shift_buffer(shift_buffer), .window_en(window_en), .window_valid(window_valid),
    .row_advance(row_advance), .row_step(row_step), .win_col(win_col),
    .win_row(win_row), .busy(busy), .done(done),
`ifdef CONV_SCHED_PERF_EN
    .stall_cnt(stall_cnt), .win_cnt(win_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int ra_cnt = 0;
  int stall_cycles = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_buffer !== window_en) check("shift_eq_en", shift_buffer, window_en);
      if (window_valid) begin
        check("no_shift_in_emit", shift_buffer, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_window", 1, 0);
        end else if (mac_ready) begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("win_col", win_col, e[7:0]);
          check("win_row", win_row, e[15:8]);
          hs_cnt++;
        end else begin
          logic [15:0] h;
          h = exp_q[0];
          stall_cycles++;
          check("stall_hold_col", win_col, h[7:0]);
        end
      end
      if (row_advance) ra_cnt++;
      if (done) done_cnt++;
    end
  end

  // Hand-computed window corner lists for the 8x8 image.
  task automatic push_expected(input int eff, output int n);
    int lst[$];
    case (eff)
      1:       lst = '{0, 1, 2, 3, 4, 5};
      2:       lst = '{0, 2, 4};
      default: lst = '{0, 3};
    endcase
    n = 0;
    foreach (lst[r]) begin
      foreach (lst[c]) begin
        logic [7:0] rr, cc;
        rr = 8'(lst[r]);
        cc = 8'(lst[c]);
        exp_q.push_back({rr, cc});
        n++;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_shift"}, shift_buffer, 0);
    check({tag, "_wen"}, window_en, 0);
    check({tag, "_valid"}, window_valid, 0);
    check({tag, "_rowadv"}, row_advance, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // stall_w: index (1-based) of window held off for 5 cycles, -1 for none.
  // abort_row: assert rst in STEP of this window row, -1 for none.
  task automatic run_frame(input logic [1:0] s, input int eff, input int exp_ra,
                           input bit disturb, input int stall_w, input int abort_row);
    int  nwin;
    int  stall_left;
    bit  finished;
    bit  aborted;
    push_expected(eff, nwin);
    hs_cnt = 0; done_cnt = 0; ra_cnt = 0; stall_cycles = 0;
    stall_left = 5;
    finished = 0; aborted = 0;
    @(posedge clk); #1;
    stride = s; start = 1'b1; mac_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (window_valid && hs_cnt == stall_w - 1 && stall_left > 0) begin
        mac_ready = 1'b0;
        stall_left--;
      end else begin
        mac_ready = 1'b1;
      end
      if (disturb) begin
        if (cyc == 10 || cyc == 40) begin start = 1'b1; stride = 2'd3; end
        if (cyc == 11 || cyc == 41) start = 1'b0;
      end
      if (abort_row >= 0 && state_dbg == 3'd3 && win_row == 8'(abort_row)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("abort");
        check("abort_col", win_col, 0);
        check("abort_row_q", win_row, 0);
        check("abort_step", row_step, 0);
        rst = 1'b0;
        mac_ready = 1'b1;
        check("abort_no_done", done_cnt, 0);
        exp_q.delete();
        aborted = 1;
        break;
      end
      if (done_cnt > 0) begin
        finished = 1;
        break;
      end
    end
    if (aborted) return;
    check("frame_completed", finished, 1);
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", busy, 0);
    check("idle_after_done", state_dbg, 0);
    check("windows", hs_cnt, nwin);
    check("exp_q_empty", exp_q.size(), 0);
    check("row_advances", ra_cnt, exp_ra);
    check("row_step", row_step, eff);
    check("stall_cycles", stall_cycles, (stall_w > 0) ? 5 : 0);
`ifdef CONV_SCHED_PERF_EN
    check("perf_stall_cnt", int'(stall_cnt), (stall_w > 0) ? 5 : 0);
    check("perf_win_cnt", int'(win_cnt), nwin);
`endif
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stride = 2'd0; mac_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_col", win_col, 0);
    check("reset_row", win_row, 0);
    rst = 1'b0;

    run_frame(2'd1, 1, 5, 1'b0, -1, -1);  // T1
    run_frame(2'd2, 2, 2, 1'b0, -1, -1);  // T2
    run_frame(2'd3, 3, 1, 1'b0, -1, -1);  // T3
    run_frame(2'd0, 1, 5, 1'b0, -1, -1);  // stride 0 acts as 1
    run_frame(2'd1, 1, 5, 1'b0, 2, -1);   // T4 stall on 2nd window
    run_frame(2'd1, 1, 5, 1'b1, -1, -1);  // T5 start/stride disturbance
    run_frame(2'd1, 1, 5, 1'b0, -1, 2);   // T6 abort in row 2
    run_frame(2'd1, 1, 5, 1'b0, -1, -1);  // full frame after abort

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
